// File: rtl/pool2x2_stream.sv
// Streaming 2x2 / stride-2 max/average pooling over a raster-order feature map,
// buffering one half-row of partial window results. Optional macro: POOL2X2_ARGMAX_EN.
module pool2x2_stream #(
    parameter int DW    = 16,
    parameter int MAP_W = 6,
    parameter int MAP_H = 6,
    localparam int NOUT = MAP_W * MAP_H / 4,
    localparam int AW   = (NOUT > 1) ? $clog2(NOUT) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    out_idx,
    output logic [AW-1:0] out_addr,
    output logic          frame_done
);

    localparam int CW = $clog2(MAP_W);
    localparam int RW = $clog2(MAP_H);
    localparam int PD = MAP_W / 2;
    localparam int PW = (PD > 1) ? $clog2(PD) : 1;
    localparam int VW = DW + 2;

    localparam logic [CW-1:0] COL_LAST  = CW'(MAP_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(MAP_H - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(NOUT - 1);

    typedef enum logic {
        EVEN_ROW = 1'b0,
        ODD_ROW  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            mode_q, mode_d;
    logic [VW-1:0]   tmp_val_q, tmp_val_d;
    logic [VW-1:0]   pbuf_val [PD];
    logic            pbuf_we;

    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [AW-1:0]   out_addr_q, out_addr_d;
    logic            frame_done_q, frame_done_d;

    logic            in_fire;
    logic            out_fire;
    logic            col_last;
    logic            row_last;
    logic            col_odd;
    logic [PW-1:0]   pidx;
    logic [VW-1:0]   smp_ext;
    logic [VW-1:0]   opa_val;
    logic [VW-1:0]   cmb_val;
    logic            a_wins;

    assign in_ready = ~out_valid_q | out_ready;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid_q & out_ready;
    assign col_last = (col_q == COL_LAST);
    assign row_last = (row_q == ROW_LAST);
    assign col_odd  = col_q[0];
    assign pidx     = PW'(col_q >> 1);
    assign smp_ext  = {{2{in_data[DW-1]}}, in_data};

    // The earlier operand is the half-row entry on an even column of an odd row,
    // otherwise the pending partial in tmp.
    assign opa_val = (state_q == ODD_ROW && !col_odd) ? pbuf_val[pidx] : tmp_val_q;
    assign a_wins  = $signed(opa_val) >= $signed(smp_ext);
    assign cmb_val = mode_q ? (opa_val + smp_ext) : (a_wins ? opa_val : smp_ext);

`ifdef POOL2X2_ARGMAX_EN
    logic [1:0] tmp_idx_q, tmp_idx_d;
    logic [1:0] pbuf_idx [PD];
    logic [1:0] opa_idx;
    logic [1:0] smp_idx;
    logic [1:0] cmb_idx;
    logic [1:0] out_idx_q, out_idx_d;

    assign opa_idx = (state_q == ODD_ROW && !col_odd) ? pbuf_idx[pidx] : tmp_idx_q;
    assign smp_idx = {state_q == ODD_ROW, col_odd};
    assign cmb_idx = mode_q ? 2'd0 : (a_wins ? opa_idx : smp_idx);
    assign out_idx = out_idx_q;
`else
    assign out_idx = 2'd0;
`endif

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_addr   = out_addr_q;
    assign frame_done = frame_done_q;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        mode_d       = mode_q;
        tmp_val_d    = tmp_val_q;
        pbuf_we      = 1'b0;
        out_valid_d  = out_valid_q & ~out_ready;
        out_data_d   = out_data_q;
        out_addr_d   = out_addr_q;
        frame_done_d = out_fire && (out_addr_q == ADDR_LAST);
`ifdef POOL2X2_ARGMAX_EN
        tmp_idx_d    = tmp_idx_q;
        out_idx_d    = out_idx_q;
`endif

        if (out_fire) begin
            out_addr_d = (out_addr_q == ADDR_LAST) ? '0 : out_addr_q + 1'b1;
        end

        if (in_fire) begin
            if (row_q == '0 && col_q == '0) begin
                mode_d = mode;
            end
            if (col_last) begin
                col_d   = '0;
                row_d   = row_last ? '0 : row_q + 1'b1;
                state_d = (state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
            end else begin
                col_d = col_q + 1'b1;
            end

            case (state_q)
                EVEN_ROW: begin
                    if (col_odd) begin
                        pbuf_we = 1'b1;
                    end else begin
                        tmp_val_d = smp_ext;
`ifdef POOL2X2_ARGMAX_EN
                        tmp_idx_d = 2'd0;
`endif
                    end
                end
                default: begin
                    if (!col_odd) begin
                        tmp_val_d = cmb_val;
`ifdef POOL2X2_ARGMAX_EN
                        tmp_idx_d = cmb_idx;
`endif
                    end else begin
                        out_valid_d = 1'b1;
                        // Bits [DW+1:2] of the sum are the floored divide-by-4 truncated to DW.
                        out_data_d  = mode_q ? cmb_val[DW+1:2] : cmb_val[DW-1:0];
`ifdef POOL2X2_ARGMAX_EN
                        out_idx_d   = cmb_idx;
`endif
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EVEN_ROW;
            col_q        <= '0;
            row_q        <= '0;
            mode_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_addr_q   <= '0;
            frame_done_q <= 1'b0;
`ifdef POOL2X2_ARGMAX_EN
            out_idx_q    <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            mode_q       <= mode_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_addr_q   <= out_addr_d;
            frame_done_q <= frame_done_d;
`ifdef POOL2X2_ARGMAX_EN
            out_idx_q    <= out_idx_d;
`endif
        end
    end

    // Partial-result storage carries no reset; stale contents are always overwritten
    // before being read within a frame.
    always_ff @(posedge clk) begin
        tmp_val_q <= tmp_val_d;
`ifdef POOL2X2_ARGMAX_EN
        tmp_idx_q <= tmp_idx_d;
`endif
        if (pbuf_we) begin
            pbuf_val[pidx] <= cmb_val;
`ifdef POOL2X2_ARGMAX_EN
            pbuf_idx[pidx] <= cmb_idx;
`endif
        end
    end

endmodule

// File: doc/pool2x2_stream.md
# pool2x2_stream

Streaming 2x2 / stride-2 pooling engine for the CNN datapath, successor to the frame-buffered max-pool block. Accepts a feature map in raster order over a valid/ready handshake and holds only one half-row of partial results, not the whole map. Supports runtime-selectable max or average pooling, signed data of parametrised width, and arbitrary even map dimensions. Emits one pooled value per window with its output address, optional argmax index, and a frame-done pulse.

## Interface
- `DW`, 16, data width; samples are two's-complement signed.
- `MAP_W`, 6, input map width; even, >= 2.
- `MAP_H`, 6, input map height; even, >= 2.
- `AW`, derived localparam, `$clog2(MAP_W*MAP_H/4)` with a minimum of 1; output address width.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  1  0 = max, 1 = average; sampled on the first accepted beat of each frame.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  block can accept a sample.
- `in_data`  in  DW  input sample.
- `out_valid`  out  1  pooled result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  DW  pooled value.
- `out_idx`  out  2  argmax position within the window: 0=(r,c), 1=(r,c+1), 2=(r+1,c), 3=(r+1,c+1). Driven 0 in average mode.
- `out_addr`  out  AW  output index, `(r/2)*(MAP_W/2) + c/2`.
- `frame_done`  out  1  one-cycle pulse after the last result of a frame is handshaken.

## Operation
- Counters `row` (0..MAP_H-1) and `col` (0..MAP_W-1) advance on each input handshake (`in_valid & in_ready`). `col` wraps to 0 at MAP_W-1 and increments `row`.
- State machine, 2 states:
  - `EVEN_ROW` covers rows 0, 2, 4, …. On an even `col`, the sample is latched into `tmp`. On an odd `col`, `tmp` is combined with the sample and written to `pbuf[col/2]`. At the last `col`, move to `ODD_ROW`.
  - `ODD_ROW` covers rows 1, 3, …. On an even `col`, `pbuf[col/2]` is combined with the sample and written to `tmp`. On an odd `col`, `tmp` is combined with the sample and the final result is loaded into the output register, with `out_valid` set to 1. At the last `col`, go back to `EVEN_ROW`. If this was also the last row, the frame is complete and the counters return to 0.
- Combine rules:
  - Max mode: signed compare with `>=`, so the earlier position wins ties. The index of the winning entry travels with the value.
  - Average mode: sums are carried at DW+2 bits with sign extension. The final value is `sum >>> 2`, an arithmetic shift that floors toward -inf, truncated to DW bits.
- `pbuf` depth is MAP_W/2. Each entry holds DW+2 bits of value plus 2 bits of index.
- `mode` is captured into `mode_q` when a handshake occurs at row 0, col 0. Changes to `mode` mid-frame are ignored.
- `out_addr` is a counter. It increments on each output handshake and wraps to 0 after the last result of a frame.
- `frame_done` is asserted for one cycle on the cycle after the output handshake of address `MAP_W*MAP_H/4 - 1`.
- A frame may follow the previous one with no gap.

## Timing
- `in_ready = ~out_valid | out_ready`. This rule applies to every beat, including beats that do not complete a window.
- Latency: `out_valid` is asserted on the cycle after the handshake of the window's fourth sample.
- While `out_valid` is high and `out_ready` is low, `out_data`, `out_idx` and `out_addr` stay stable.
- The output register is a single entry. A new result may load on the same cycle the old one is handshaken, which gives full throughput.
- Reset values, all taking effect on the edge where `rst` is high:
  - `out_valid`=0, `out_data`=0, `out_idx`=0, `out_addr`=0, `frame_done`=0.
  - State = `EVEN_ROW`, `row`=`col`=0, `mode_q`=0.
  - `pbuf` and `tmp` are don't-care.
- Reset mid-frame discards all partial results and any pending output. The next accepted sample is treated as row 0, col 0.
- `in_valid` low: no state change. A partially formed window persists indefinitely.

## Configuration
- `POOL2X2_ARGMAX_EN` defined:
  - Index tracking is compiled in.
  - `out_idx` reports the argmax position as described above.
- Not defined:
  - Index storage and index muxing are removed.
  - `out_idx` is tied to 2'd0.
  - Values in both modes are unchanged.

## Test plan
- **Max, 4x4 map:** inputs 0..15 in raster order, mode=0, `out_ready`=1 → outputs (5,3,0), (7,3,1), (13,3,2), (15,3,3) as (data,idx,addr). `frame_done` pulses once, 1 cycle after addr 3.
- **Average, 4x4 map:** same inputs, mode=1 → out_data = 2, 4, 10, 12; out_idx = 0.
- **Signed and ties, 2x2 map:**
  - Window -1, -2, -3, -4 in average mode → -3 (floor of -2.5).
  - Window 7, 7, 7, 7 in max mode → data 7, idx 0.
  - Window -5, 9, 9, -5 in max mode → data 9, idx 1.
- **Backpressure:** hold `out_ready`=0 after the first result → `in_ready` drops and `out_data` stays 5 until release. The full 4x4 result sequence is unchanged, with no loss or duplication.
- **Mode change and back-to-back frames:** toggle `mode` mid-frame → no effect on the current frame. The next frame, started with no gap, uses the new mode and `out_addr` restarts at 0.
- **Reset mid-frame:** assert `rst` after 6 samples → all outputs 0. A full 4x4 frame afterwards produces correct results identical to the first scenario.
